// File: rtl/button_panel_pkg.sv
// Shared helpers and default sizing for the button panel.
package button_panel_pkg;

    // Minimum number of bits able to hold values 0 .. value-1 (never below 1).
    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < 32'(value)) begin
                bits = i + 1;
            end
        end
        return (bits < 1) ? 1 : bits;
    endfunction

    localparam int DEF_DEBOUNCE_CYCLES   = 50000;
    localparam int DEF_LED_PULSE_CYCLES  = 5000000;
    localparam int DEF_LONG_PRESS_CYCLES = 50000000;

    // Debounce counter stops at N-1, LED timer holds N, hold counter saturates at N+1.
    localparam int DEF_DEBOUNCE_W = clog2(DEF_DEBOUNCE_CYCLES);
    localparam int DEF_LED_W      = clog2(DEF_LED_PULSE_CYCLES + 1);
    localparam int DEF_HOLD_W     = clog2(DEF_LONG_PRESS_CYCLES + 2);

    localparam logic PRESSED_LEVEL = 1'b1;

endpackage

// File: rtl/button_channel.sv
// One button channel: synchroniser, debounce, press strobe, press counter and,
// with BUTTON_PANEL_LONG_PRESS_EN defined, a long-press hold counter.
module button_channel
    import button_panel_pkg::*;
#(
    parameter int COUNT_WIDTH       = 8,
    parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_button,
    input  logic                   i_clear,
    output logic                   o_debounced,
    output logic                   o_press,
    output logic                   o_long_press,
    output logic [COUNT_WIDTH-1:0] o_count
);

    localparam int              DB_W    = clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]             sync_r;
    logic                   deb_r;
    logic [DB_W-1:0]        deb_cnt_r;
    logic                   deb_dly_r;
    logic                   press_r;
    logic [COUNT_WIDTH-1:0] count_r;
    logic                   pressed_s;
    logic                   rise_s;
    logic                   long_hit_s;

    assign pressed_s = (sync_r[1] == PRESSED_LEVEL);
    assign rise_s    = deb_r & ~deb_dly_r;

    // Two-flop synchroniser for the raw asynchronous button.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], i_button};
        end
    end

    // Debounce: accept a new level only after it differs for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            deb_r     <= 1'b0;
            deb_cnt_r <= '0;
        end else if (pressed_s == deb_r) begin
            deb_cnt_r <= '0;
        end else if (deb_cnt_r == DB_LAST) begin
            deb_r     <= pressed_s;
            deb_cnt_r <= '0;
        end else begin
            deb_cnt_r <= deb_cnt_r + DB_W'(1);
        end
    end

    // Registered rising-edge detect of the debounced level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            deb_dly_r <= 1'b0;
            press_r   <= 1'b0;
        end else begin
            deb_dly_r <= deb_r;
            press_r   <= rise_s;
        end
    end

    // Wrapping press counter; any clear beats a same-cycle increment.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_r <= '0;
        end else if (i_clear || long_hit_s) begin
            count_r <= '0;
        end else if (rise_s) begin
            count_r <= count_r + COUNT_WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

`ifdef BUTTON_PANEL_LONG_PRESS_EN
    localparam int                HOLD_W   = clog2(LONG_PRESS_CYCLES + 2);
    localparam logic [HOLD_W-1:0] HOLD_HIT = HOLD_W'(LONG_PRESS_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'(LONG_PRESS_CYCLES + 1);

    logic [HOLD_W-1:0] hold_r;
    logic              long_r;

    assign long_hit_s   = deb_r && (hold_r == HOLD_HIT);
    assign o_long_press = long_r;

    // Hold counter saturates past the hit value so one hold strobes only once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hold_r <= '0;
            long_r <= 1'b0;
        end else begin
            long_r <= long_hit_s;
            if (!deb_r) begin
                hold_r <= '0;
            end else if (hold_r != HOLD_SAT) begin
                hold_r <= hold_r + HOLD_W'(1);
            end else begin
                hold_r <= hold_r;
            end
        end
    end
`else
    // Never true; keeps the hold limit referenced when long press is compiled out.
    assign long_hit_s   = (LONG_PRESS_CYCLES < 0);
    assign o_long_press = 1'b0;
`endif

    assign o_debounced = deb_r;
    assign o_press     = press_r;
    assign o_count     = count_r;

endmodule

// File: rtl/button_panel.sv
// Multi-channel debounced button panel with press counters and a stretched
// activity LED; long-press detection is built when BUTTON_PANEL_LONG_PRESS_EN is defined.
module button_panel
    import button_panel_pkg::*;
#(
    parameter int NUM_BUTTONS       = 4,
    parameter int COUNT_WIDTH       = 8,
    parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int LED_PULSE_CYCLES  = DEF_LED_PULSE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic [NUM_BUTTONS-1:0]             i_button,
    input  logic                               i_clear,
    output logic [NUM_BUTTONS-1:0]             o_debounced,
    output logic [NUM_BUTTONS-1:0]             o_press,
    output logic [NUM_BUTTONS-1:0]             o_long_press,
    output logic [NUM_BUTTONS*COUNT_WIDTH-1:0] o_count,
    output logic                               o_led
);

    localparam int               LED_W    = clog2(LED_PULSE_CYCLES + 1);
    localparam logic [LED_W-1:0] LED_LOAD = LED_W'(LED_PULSE_CYCLES);

    logic [NUM_BUTTONS-1:0] press_s;
    logic [LED_W-1:0]       led_timer_r;
    logic                   led_r;

    for (genvar k = 0; k < NUM_BUTTONS; k++) begin : g_chan
        button_channel #(
            .COUNT_WIDTH       (COUNT_WIDTH),
            .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES)
        ) u_chan (
            .i_clk        (i_clk),
            .i_rst_n      (i_rst_n),
            .i_button     (i_button[k]),
            .i_clear      (i_clear),
            .o_debounced  (o_debounced[k]),
            .o_press      (press_s[k]),
            .o_long_press (o_long_press[k]),
            .o_count      (o_count[k*COUNT_WIDTH +: COUNT_WIDTH])
        );
    end

    // Retriggerable LED timer; the LED flag tracks timer != 0 as a register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            led_timer_r <= '0;
            led_r       <= 1'b0;
        end else if (|press_s) begin
            led_timer_r <= LED_LOAD;
            led_r       <= 1'b1;
        end else if (led_timer_r != '0) begin
            led_timer_r <= led_timer_r - LED_W'(1);
            led_r       <= (led_timer_r != LED_W'(1));
        end else begin
            led_timer_r <= led_timer_r;
            led_r       <= 1'b0;
        end
    end

    assign o_press = press_s;
    assign o_led   = led_r;

endmodule
